// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-jump squash,
// and whole-pipe freeze while a memory-stage serial access waits on its handshake.
module pipeline_hazard_controller #(
  parameter int LOAD_DELAY     = 1,
  parameter int SERIAL_TIMEOUT = 1023,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [4:0]           dec_rs_in,
  input  logic [4:0]           dec_rt_in,
  input  logic                 dec_uses_rt_in,
  input  logic                 dec_jump_taken_in,
  input  logic                 ex_mem_read_in,
  input  logic [4:0]           ex_write_dest_in,
  input  logic                 mem_serial_rd_in,
  input  logic                 mem_serial_wr_in,
  input  logic                 serial_valid_in,
  input  logic                 serial_ready_in,
  output logic                 stall_fetch_out,
  output logic                 stall_decode_out,
  output logic                 bubble_execute_out,
  output logic                 flush_decode_out,
  output logic                 freeze_pipe_out,
  output logic                 serial_timeout_out,
  output logic [CNT_WIDTH-1:0] stall_count_out,
  output logic [1:0]           dbg_state_out
);

  localparam int WAIT_W = (SERIAL_TIMEOUT > 1) ? $clog2(SERIAL_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(SERIAL_TIMEOUT);
  localparam logic [2:0] LD_RELOAD = 3'(LOAD_DELAY - 1);

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_LOAD_STALL  = 2'd1,
    ST_SERIAL_WAIT = 2'd2
  } state_t;

  state_t               r_state;
  logic [2:0]           r_ld_cnt;
  logic [2:0]           r_saved_cnt;
  logic [WAIT_W-1:0]    r_wait_cnt;
  logic                 r_timeout;
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  state_t               w_next_state;
  logic [2:0]           w_next_ld;
  logic [2:0]           w_next_saved;
  logic [WAIT_W-1:0]    w_next_wait;
  logic                 w_set_timeout;
  logic                 w_sreq;
  logic                 w_hz;
  logic                 w_timeout_hit;
  logic                 w_stall_f;
  logic                 w_stall_d;
  logic                 w_bubble;
  logic                 w_flush;
  logic                 w_freeze;

  // A serial access whose handshake is already met this cycle costs no wait.
  assign w_sreq = (mem_serial_rd_in & ~serial_valid_in) |
                  (mem_serial_wr_in & ~serial_ready_in);

  assign w_hz = ex_mem_read_in & (ex_write_dest_in != 5'd0) &
                ((ex_write_dest_in == dec_rs_in) |
                 (dec_uses_rt_in & (ex_write_dest_in == dec_rt_in)));

  // The wait counter reaches the limit after SERIAL_TIMEOUT frozen cycles inside SERIAL_WAIT.
  assign w_timeout_hit = (SERIAL_TIMEOUT != 0) && (r_wait_cnt == TIMEOUT_VAL);

  always_comb begin
    w_next_state  = r_state;
    w_next_ld     = r_ld_cnt;
    w_next_saved  = r_saved_cnt;
    w_next_wait   = r_wait_cnt;
    w_set_timeout = 1'b0;
    w_stall_f     = 1'b0;
    w_stall_d     = 1'b0;
    w_bubble      = 1'b0;
    w_flush       = 1'b0;
    w_freeze      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_sreq) begin
          w_freeze     = 1'b1;
          w_stall_f    = 1'b1;
          w_stall_d    = 1'b1;
          w_next_wait  = '0;
          w_next_saved = 3'd0;
          w_next_state = ST_SERIAL_WAIT;
        end else if (w_hz) begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_bubble  = 1'b1;
          if (LOAD_DELAY > 1) begin
            w_next_ld    = LD_RELOAD;
            w_next_state = ST_LOAD_STALL;
          end
        end else if (dec_jump_taken_in) begin
          w_flush = 1'b1;
        end
      end
      ST_LOAD_STALL: begin
        if (w_sreq) begin
          w_freeze     = 1'b1;
          w_stall_f    = 1'b1;
          w_stall_d    = 1'b1;
          w_next_saved = r_ld_cnt;
          w_next_wait  = '0;
          w_next_state = ST_SERIAL_WAIT;
        end else begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_bubble  = 1'b1;
          if (r_ld_cnt <= 3'd1) begin
            w_next_ld    = 3'd0;
            w_next_state = ST_RUN;
          end else begin
            w_next_ld = r_ld_cnt - 3'd1;
          end
        end
      end
      ST_SERIAL_WAIT: begin
        if (w_sreq && !w_timeout_hit) begin
          w_freeze    = 1'b1;
          w_stall_f   = 1'b1;
          w_stall_d   = 1'b1;
          w_next_wait = r_wait_cnt + 1'b1;
        end else begin
          w_set_timeout = w_sreq;
          // An interrupted load stall resumes in the release cycle itself.
          if (r_saved_cnt != 3'd0) begin
            w_stall_f    = 1'b1;
            w_stall_d    = 1'b1;
            w_bubble     = 1'b1;
            w_next_saved = 3'd0;
            if (r_saved_cnt == 3'd1) begin
              w_next_ld    = 3'd0;
              w_next_state = ST_RUN;
            end else begin
              w_next_ld    = r_saved_cnt - 3'd1;
              w_next_state = ST_LOAD_STALL;
            end
          end else begin
            w_next_state = ST_RUN;
          end
        end
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_ld_cnt    <= 3'd0;
      r_saved_cnt <= 3'd0;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_ld_cnt    <= w_next_ld;
      r_saved_cnt <= w_next_saved;
      r_wait_cnt  <= w_next_wait;
      r_timeout   <= r_timeout | w_set_timeout;
      if (w_stall_f && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  // Mealy controls are gated by reset so every output is quiet while reset is held.
  assign stall_fetch_out    = w_stall_f & reset;
  assign stall_decode_out   = w_stall_d & reset;
  assign bubble_execute_out = w_bubble & reset;
  assign flush_decode_out   = w_flush & reset;
  assign freeze_pipe_out    = w_freeze & reset;
  assign serial_timeout_out = (r_timeout | w_set_timeout) & reset;
  assign stall_count_out    = r_stall_cnt;
  assign dbg_state_out      = r_state;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: expected control vectors are queued with
// each stimulus step and popped when the outputs are sampled mid-cycle.
module tb_pipeline_hazard_controller;

  logic        clock;
  logic        reset;
  logic [4:0]  dec_rs_in;
  logic [4:0]  dec_rt_in;
  logic        dec_uses_rt_in;
  logic        dec_jump_taken_in;
  logic        ex_mem_read_in;
  logic [4:0]  ex_write_dest_in;
  logic        mem_serial_rd_in;
  logic        mem_serial_wr_in;
  logic        serial_valid_in;
  logic        serial_ready_in;

  logic        stall_fetch_out, stall_decode_out, bubble_execute_out;
  logic        flush_decode_out, freeze_pipe_out, serial_timeout_out;
  logic [15:0] stall_count_out;
  logic [1:0]  dbg_state_out;

  logic        d3_stall_fetch, d3_stall_decode, d3_bubble, d3_flush, d3_freeze, d3_timeout;
  logic [15:0] d3_stall_count;
  logic [1:0]  d3_state;

  int checks = 0;
  int errors = 0;

  // {stall_fetch, stall_decode, bubble, flush, freeze, timeout}
  logic [5:0] exp_q[$];
  string      tag_q[$];

  localparam logic [5:0] E_IDLE   = 6'b000000;
  localparam logic [5:0] E_HAZ    = 6'b111000;
  localparam logic [5:0] E_FLUSH  = 6'b000100;
  localparam logic [5:0] E_FREEZE = 6'b110010;
  localparam logic [5:0] E_TO     = 6'b000001;

  pipeline_hazard_controller #(
    .LOAD_DELAY(1), .SERIAL_TIMEOUT(8), .CNT_WIDTH(16)
  ) u_dut (
    .clock(clock), .reset(reset),
    .dec_rs_in(dec_rs_in), .dec_rt_in(dec_rt_in), .dec_uses_rt_in(dec_uses_rt_in),
    .dec_jump_taken_in(dec_jump_taken_in), .ex_mem_read_in(ex_mem_read_in),
    .ex_write_dest_in(ex_write_dest_in), .mem_serial_rd_in(mem_serial_rd_in),
    .mem_serial_wr_in(mem_serial_wr_in), .serial_valid_in(serial_valid_in),
    .serial_ready_in(serial_ready_in),
    .stall_fetch_out(stall_fetch_out), .stall_decode_out(stall_decode_out),
    .bubble_execute_out(bubble_execute_out), .flush_decode_out(flush_decode_out),
    .freeze_pipe_out(freeze_pipe_out), .serial_timeout_out(serial_timeout_out),
    .stall_count_out(stall_count_out), .dbg_state_out(dbg_state_out)
  );

  pipeline_hazard_controller #(
    .LOAD_DELAY(3), .SERIAL_TIMEOUT(8), .CNT_WIDTH(16)
  ) u_dut3 (
    .clock(clock), .reset(reset),
    .dec_rs_in(dec_rs_in), .dec_rt_in(dec_rt_in), .dec_uses_rt_in(dec_uses_rt_in),
    .dec_jump_taken_in(dec_jump_taken_in), .ex_mem_read_in(ex_mem_read_in),
    .ex_write_dest_in(ex_write_dest_in), .mem_serial_rd_in(mem_serial_rd_in),
    .mem_serial_wr_in(mem_serial_wr_in), .serial_valid_in(serial_valid_in),
    .serial_ready_in(serial_ready_in),
    .stall_fetch_out(d3_stall_fetch), .stall_decode_out(d3_stall_decode),
    .bubble_execute_out(d3_bubble), .flush_decode_out(d3_flush),
    .freeze_pipe_out(d3_freeze), .serial_timeout_out(d3_timeout),
    .stall_count_out(d3_stall_count), .dbg_state_out(d3_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle_inputs();
    dec_rs_in = 5'd0; dec_rt_in = 5'd0; dec_uses_rt_in = 1'b0; dec_jump_taken_in = 1'b0;
    ex_mem_read_in = 1'b0; ex_write_dest_in = 5'd0;
    mem_serial_rd_in = 1'b0; mem_serial_wr_in = 1'b0;
    serial_valid_in = 1'b0; serial_ready_in = 1'b0;
  endtask

  task automatic drive_load(input logic [4:0] dest, input logic [4:0] rs,
                            input logic [4:0] rt, input logic uses_rt);
    ex_mem_read_in = 1'b1; ex_write_dest_in = dest;
    dec_rs_in = rs; dec_rt_in = rt; dec_uses_rt_in = uses_rt;
  endtask

  task automatic check_outputs();
    logic [5:0] obs;
    logic [5:0] exp;
    string      tag;
    obs = {stall_fetch_out, stall_decode_out, bubble_execute_out,
           flush_decode_out, freeze_pipe_out, serial_timeout_out};
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs already driven; samples at the falling edge.
  task automatic step(input string tag, input logic [5:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #4;
    check_outputs();
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    // Outputs must stay quiet in reset even with hazard-provoking inputs.
    mem_serial_rd_in = 1'b1;
    dec_jump_taken_in = 1'b1;
    drive_load(5'd5, 5'd5, 5'd0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    exp_q.push_back(E_IDLE); tag_q.push_back("in_reset");
    check_outputs();
    check_val("reset_count", stall_count_out, 16'd0);
    idle_inputs();
    #2 reset = 1'b1;
    @(posedge clock);
    #1;

    step("idle", E_IDLE);

    // Load-use on rs: one bubble for LOAD_DELAY=1, three for LOAD_DELAY=3.
    drive_load(5'd5, 5'd5, 5'd0, 1'b0);
    exp_q.push_back(E_HAZ); tag_q.push_back("load_use");
    #4;
    check_outputs();
    check_val("d3_stall_c0", {15'd0, d3_stall_fetch}, 16'd1);
    @(posedge clock); #1;
    idle_inputs();
    exp_q.push_back(E_IDLE); tag_q.push_back("load_use_done");
    #4;
    check_outputs();
    check_val("d3_stall_c1", {15'd0, d3_bubble}, 16'd1);
    @(posedge clock); #1;
    check_val("count_after_load", stall_count_out, 16'd1);
    #4;
    check_val("d3_stall_c2", {15'd0, d3_stall_fetch}, 16'd1);
    @(posedge clock); #4;
    check_val("d3_stall_c3", {15'd0, d3_stall_fetch}, 16'd0);
    @(posedge clock); #1;
    check_val("d3_count", d3_stall_count, 16'd3);
    check_val("d3_state_run", {14'd0, d3_state}, 16'd0);

    // Register 0 and an unused rt never stall; a used rt does.
    drive_load(5'd0, 5'd0, 5'd0, 1'b1);
    step("dest_zero", E_IDLE);
    drive_load(5'd7, 5'd3, 5'd7, 1'b0);
    step("rt_unused", E_IDLE);
    drive_load(5'd7, 5'd3, 5'd7, 1'b1);
    step("rt_used", E_HAZ);
    idle_inputs();
    check_val("count_rt", stall_count_out, 16'd2);

    // Hazard suppresses the flush; the re-resolved jump then flushes once.
    drive_load(5'd5, 5'd5, 5'd0, 1'b0);
    dec_jump_taken_in = 1'b1;
    step("jump_collision", E_HAZ);
    idle_inputs();
    dec_jump_taken_in = 1'b1;
    step("jump_retry", E_FLUSH);
    idle_inputs();
    step("jump_done", E_IDLE);
    check_val("count_jump", stall_count_out, 16'd3);

    // Serial read: valid low for 4 cycles, freeze drops the cycle valid rises.
    mem_serial_rd_in = 1'b1;
    for (int i = 0; i < 4; i++) step("serial_rd_wait", E_FREEZE);
    serial_valid_in = 1'b1;
    step("serial_rd_release", E_IDLE);
    idle_inputs();
    check_val("count_serial", stall_count_out, 16'd7);
    mem_serial_wr_in = 1'b1; serial_ready_in = 1'b1;
    step("serial_wr_zero_wait", E_IDLE);
    idle_inputs();

    // Timeout: entry cycle plus 8 wait cycles frozen, then release with sticky flag.
    mem_serial_wr_in = 1'b1;
    for (int i = 0; i < 9; i++) step("timeout_wait", E_FREEZE);
    step("timeout_release", E_TO);
    idle_inputs();
    step("timeout_sticky", E_TO);
    step("timeout_sticky2", E_TO);
    check_val("count_timeout", stall_count_out, 16'd16);

    // Reset dropped mid-wait aborts everything asynchronously.
    mem_serial_rd_in = 1'b1;
    step("wait_pre_reset", E_FREEZE | E_TO);
    step("wait_pre_reset2", E_FREEZE | E_TO);
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(E_IDLE); tag_q.push_back("async_reset");
    check_outputs();
    check_val("async_reset_count", stall_count_out, 16'd0);
    @(posedge clock); #1;
    idle_inputs();
    #2 reset = 1'b1;
    @(posedge clock); #1;
    check_val("post_reset_state", {14'd0, dbg_state_out}, 16'd0);
    step("post_reset_idle", E_IDLE);
    mem_serial_rd_in = 1'b1;
    step("post_reset_serial", E_FREEZE);
    serial_valid_in = 1'b1;
    step("post_reset_release", E_IDLE);
    idle_inputs();
    check_val("post_reset_count", stall_count_out, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
